// File: rtl/sp_bram_acc_pkg.sv
// Shared types for the single-port BRAM burst engine.
package sp_bram_acc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/sp_bram_acc_fifo2.sv
// Two-entry FIFO holding {last, data} read beats; push and pop may coincide.
module sp_bram_acc_fifo2
  import sp_bram_acc_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);
  logic [FIFO_DEPTH-1:0][W-1:0] mem;
  logic wptr, rptr;
  logic do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == 2'd0);
endmodule

// File: rtl/sp_bram_acc.sv
// Burst initiator for a write-first single-port BRAM with one-cycle read latency.
module sp_bram_acc
  import sp_bram_acc_pkg::*;
#(
  parameter int G_ADDR  = 6,
  parameter int G_WIDTH = 16,
  parameter int G_LEN   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic               cmd_wr,
  input  logic [G_ADDR-1:0]  cmd_addr,
  input  logic [G_LEN-1:0]   cmd_len,
  input  logic [G_WIDTH-1:0] wr_data,
  input  logic               wr_vld,
  output logic               wr_rdy,
  output logic [G_WIDTH-1:0] rd_data,
  output logic               rd_vld,
  input  logic               rd_rdy,
  output logic               rd_last,
  output logic               ram_we,
  output logic [G_ADDR-1:0]  ram_addr,
  output logic [G_WIDTH-1:0] ram_din,
  input  logic [G_WIDTH-1:0] ram_dout,
  output logic               busy
);
  state_t state, state_nx;
  logic [G_ADDR-1:0]  addr_q;
  logic [G_LEN-1:0]   cnt_q;
  logic               inflight, infl_last;
  logic [1:0]         fifo_count;
  logic               fifo_empty;
  logic [G_WIDTH:0]   fifo_dout;
  logic               cmd_hs, wr_hs, issue, pop, last_beat;
  logic [2:0]         credit_use;

  assign last_beat  = (cnt_q == '0);
  assign pop        = rd_vld && rd_rdy;
  // Slots already committed to the FIFO once this cycle's pop retires.
  assign credit_use = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = (state == READ) && (credit_use < 3'd2);
  assign wr_hs      = (state == WRITE) && wr_vld;
  assign cmd_hs     = cmd_vld && cmd_rdy;

  always_comb begin
    state_nx = state;
    cmd_rdy  = 1'b0;
    wr_rdy   = 1'b0;
    ram_we   = 1'b0;
    ram_din  = '0;
    unique case (state)
      IDLE: begin
        cmd_rdy = rst_n;
        if (cmd_vld && rst_n) state_nx = cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        wr_rdy  = 1'b1;
        ram_we  = wr_vld;
        ram_din = wr_data;
        if (wr_vld && last_beat) state_nx = IDLE;
      end
      READ: begin
        if (issue && last_beat) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!inflight && fifo_empty) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      inflight  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      state     <= state_nx;
      inflight  <= issue;
      infl_last <= issue && last_beat;
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
      end else if (wr_hs || issue) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  sp_bram_acc_fifo2 #(.W(G_WIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   ({infl_last, ram_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_vld   = !fifo_empty;
  assign rd_data  = rd_vld ? fifo_dout[G_WIDTH-1:0] : '0;
  assign rd_last  = rd_vld && fifo_dout[G_WIDTH];
  assign ram_addr = addr_q;
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_sp_bram_acc.sv
// Directed bench for sp_bram_acc with a behavioural write-first BRAM attached.
module tb_sp_bram_acc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 0, cmd_rdy, cmd_wr = 0;
  logic [5:0]  cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_vld = 0, wr_rdy;
  logic [15:0] rd_data;
  logic        rd_vld, rd_rdy = 0, rd_last;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_bram_acc #(.G_ADDR(6), .G_WIDTH(16), .G_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_last(rd_last),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  // Write-first single-port RAM, registered read
  logic [15:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    logic cv, cw; logic [5:0] ca; logic [3:0] cl; logic wv; logic [15:0] wd; logic rr;
    logic crdy, wrdy, we; logic [5:0] ra; logic [15:0] din;
    logic rv, rl; logic [15:0] rd; logic bsy;
  } vec_t;

  vec_t vec [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr_burst(input logic [5:0] a, input logic [3:0] l,
                          input logic [15:0] base, input int gap);
    @(posedge clk); #1;
    cmd_vld = 1; cmd_wr = 1; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    chk("wr_cmd_rdy", 64'(cmd_rdy), 64'd1);
    for (int i = 0; i <= int'(l); i++) begin
      @(posedge clk); #1;
      cmd_vld = 0; wr_vld = 1; wr_data = 16'(base + i);
      @(negedge clk);
      chk("wr_beat", {wr_rdy, ram_we, ram_addr, ram_din},
          {1'b1, 1'b1, 6'(a + i), 16'(base + i)});
      if (i < int'(l)) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          wr_vld = 0; wr_data = 16'hDEAD;
          @(negedge clk);
          chk("wr_gap", {wr_rdy, ram_we, ram_addr}, {1'b1, 1'b0, 6'(a + i + 1)});
        end
      end
    end
    @(posedge clk); #1;
    wr_vld = 0;
    @(negedge clk);
    chk("wr_done", {cmd_rdy, busy, ram_we}, {1'b1, 1'b0, 1'b0});
  endtask

  // Consumes stop_after beats, checking order, last flag and outstanding depth.
  task automatic rd_burst(input logic [5:0] a, input logic [3:0] l, input logic [15:0] base,
                          input logic [3:0] rr_pat, input int stop_after, input bit chk_lat);
    int idx = 0, cyc = 0, max_out = 0, outst;
    @(posedge clk); #1;
    cmd_vld = 1; cmd_wr = 0; cmd_addr = a; cmd_len = l; rd_rdy = rr_pat[0];
    @(negedge clk);
    chk("rd_cmd_rdy", 64'(cmd_rdy), 64'd1);
    while (idx < stop_after && cyc < 200) begin
      @(posedge clk); #1;
      cmd_vld = 0; rd_rdy = rr_pat[cyc % 4]; cyc++;
      @(negedge clk);
      outst = int'(6'(ram_addr - a)) - idx;
      if (outst > max_out) max_out = outst;
      if (rd_vld && rd_rdy) begin
        chk("rd_beat", {rd_last, rd_data}, {(idx == int'(l)), 16'(base + idx)});
        if (chk_lat && idx == 0) chk("rd_latency", 64'(cyc), 64'd3);
        idx++;
      end
    end
    if (cyc >= 200) chk("rd_timeout", 64'(idx), 64'(stop_after));
    chk("rd_outstanding", 64'(max_out <= 2), 64'd1);
    rd_rdy = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_rdy && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk("idle_no_dup", {cmd_rdy, busy, rd_vld}, {1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{1,1,5,3,0,'h0000,1, 1,0,0,0,'h0000, 0,0,'h0000,0};
    vec[1]  = '{0,0,0,0,1,'hA001,1, 0,1,1,5,'hA001, 0,0,'h0000,1};
    vec[2]  = '{0,0,0,0,1,'hA002,1, 0,1,1,6,'hA002, 0,0,'h0000,1};
    vec[3]  = '{0,0,0,0,1,'hA003,1, 0,1,1,7,'hA003, 0,0,'h0000,1};
    vec[4]  = '{0,0,0,0,1,'hA004,1, 0,1,1,8,'hA004, 0,0,'h0000,1};
    vec[5]  = '{1,0,5,3,0,'h0000,1, 1,0,0,9,'h0000, 0,0,'h0000,0};
    vec[6]  = '{0,0,0,0,0,'h0000,1, 0,0,0,5,'h0000, 0,0,'h0000,1};
    vec[7]  = '{0,0,0,0,0,'h0000,1, 0,0,0,6,'h0000, 0,0,'h0000,1};
    vec[8]  = '{0,0,0,0,0,'h0000,1, 0,0,0,7,'h0000, 1,0,'hA001,1};
    vec[9]  = '{0,0,0,0,0,'h0000,1, 0,0,0,8,'h0000, 1,0,'hA002,1};
    vec[10] = '{0,0,0,0,0,'h0000,1, 0,0,0,9,'h0000, 1,0,'hA003,1};
    vec[11] = '{0,0,0,0,0,'h0000,1, 0,0,0,9,'h0000, 1,1,'hA004,1};
    vec[12] = '{0,0,0,0,0,'h0000,1, 0,0,0,9,'h0000, 0,0,'h0000,1};
    vec[13] = '{0,0,0,0,0,'h0000,1, 1,0,0,9,'h0000, 0,0,'h0000,0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_vals", {cmd_rdy, wr_rdy, rd_vld, rd_last, rd_data, ram_we, ram_addr, ram_din, busy},
        '0);
    @(posedge clk); #1;
    rst_n = 1;

    // Write then read burst at 0x05, cycle by cycle
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      cmd_vld = vec[i].cv; cmd_wr = vec[i].cw; cmd_addr = vec[i].ca; cmd_len = vec[i].cl;
      wr_vld = vec[i].wv; wr_data = vec[i].wd; rd_rdy = vec[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {cmd_rdy, wr_rdy, ram_we, ram_addr, ram_din, rd_vld, rd_last, rd_data, busy},
          {vec[i].crdy, vec[i].wrdy, vec[i].we, vec[i].ra, vec[i].din,
           vec[i].rv, vec[i].rl, vec[i].rd, vec[i].bsy});
    end

    // Address wrap round trip
    wr_burst(6'h3E, 4'd3, 16'hB001, 0);
    rd_burst(6'h3E, 4'd3, 16'hB001, 4'b1111, 4, 1'b1);
    wait_idle();

    // Write with 2-cycle valid gaps, then read under backpressure 1-0-0-1
    wr_burst(6'h10, 4'd7, 16'hC000, 2);
    rd_burst(6'h10, 4'd7, 16'hC000, 4'b1001, 8, 1'b0);
    wait_idle();

    // Reset after two beats of a read, then a clean re-read
    rd_burst(6'h05, 4'd3, 16'hA001, 4'b1111, 2, 1'b0);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("reset_mid", {cmd_rdy, wr_rdy, rd_vld, rd_last, rd_data, ram_we, ram_addr, ram_din, busy},
        '0);
    @(posedge clk); #1;
    rst_n = 1;
    rd_burst(6'h05, 4'd3, 16'hA001, 4'b1111, 4, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
